block_scroller: RTL and testbench

- Upstream stage of block_sprite. Generates the block's horizontal position (x_in) and latches the frequency and note (freq_in, true_note) that the sprite draws.
- Moves the block left by SPEED pixels once per video frame.
- When the block leaves the left edge, it respawns at X_START and requests the next detected note through a req/valid handshake.
- Outputs are registered and held stable for a whole frame, so the sprite never tears mid-frame.

---
 rtl/block_scroller_if.sv | 11 +
 rtl/block_scroller.sv | 135 +++++++++++++
 tb/tb_block_scroller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/block_scroller_if.sv
// Note handshake between the note source (master) and block_scroller (slave).
// The scroller raises note_req; the source answers with note_valid plus the note.
interface block_scroller_if;
  logic        note_req;
  logic        note_valid;
  logic [15:0] note_freq;
  logic [7:0]  note_id;

  modport master (output note_valid, output note_freq, output note_id, input note_req);
  modport slave  (input note_valid, input note_freq, input note_id, output note_req);
endinterface

// File: rtl/block_scroller.sv
// Scrolls a note block leftwards once per video frame and fetches the next note on respawn.
// All outputs are registered so the downstream sprite sees values stable for a whole frame.
module block_scroller #(
  parameter logic [12:0] X_START    = 13'd1280,
  parameter logic [12:0] SPEED      = 13'd4,
  parameter logic [9:0]  FRAME_LINE = 10'd720,
  parameter logic [15:0] FREQ_MAX   = 16'd1848
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   start,
  input  logic                   halt,
  block_scroller_if.slave        note_bus,
  output logic [12:0]            x_out,
  output logic [15:0]            freq_out,
  output logic [7:0]             note_out,
  output logic                   active,
  output logic                   passed
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_NOTE = 2'd1,
    ST_SCROLL    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] x_q, x_d;
  logic [15:0] freq_q, freq_d;
  logic [7:0]  note_q, note_d;
  logic        note_req_q, note_req_d;
  logic        active_q, active_d;
  logic        passed_q, passed_d;
  logic        frame_cond_s, frame_cond_q, tick_q;

  // Keeps (freq>>2)+gap inside the sprite column.
  function automatic logic [15:0] clamp_freq(input logic [15:0] f);
    return (f > FREQ_MAX) ? FREQ_MAX : f;
  endfunction

  assign frame_cond_s = (hcount_in == 11'd0) && (vcount_in == FRAME_LINE);

  // One tick per frame no matter how long the frame condition holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cond_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      frame_cond_q <= frame_cond_s;
      tick_q       <= frame_cond_s & ~frame_cond_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= X_START;
      freq_q     <= 16'd0;
      note_q     <= 8'd0;
      note_req_q <= 1'b0;
      active_q   <= 1'b0;
      passed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      freq_q     <= freq_d;
      note_q     <= note_d;
      note_req_q <= note_req_d;
      active_q   <= active_d;
      passed_q   <= passed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    freq_d     = freq_q;
    note_d     = note_q;
    note_req_d = 1'b0;
    active_d   = 1'b0;
    passed_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d = X_START;
        if (start) begin
          state_d    = ST_WAIT_NOTE;
          note_req_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_NOTE: begin
        if (note_bus.note_valid && note_req_q) begin
          freq_d   = clamp_freq(note_bus.note_freq);
          note_d   = note_bus.note_id;
          state_d  = ST_SCROLL;
          active_d = 1'b1;
        end else begin
          note_req_d = 1'b1;
        end
      end
      ST_SCROLL: begin
        active_d = 1'b1;
        // Respawn is tested before subtracting, so x never wraps.
        if (tick_q && !halt) begin
          if (x_q >= SPEED) begin
            x_d = x_q - SPEED;
          end else begin
            x_d        = X_START;
            passed_d   = 1'b1;
            state_d    = ST_WAIT_NOTE;
            note_req_d = 1'b1;
            active_d   = 1'b0;
          end
        end else begin
          x_d = x_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = X_START;
      end
    endcase
  end

  assign x_out             = x_q;
  assign freq_out          = freq_q;
  assign note_out          = note_q;
  assign note_bus.note_req = note_req_q;
  assign active            = active_q;
  assign passed            = passed_q;

endmodule

// File: tb/tb_block_scroller.sv
// Self-checking bench for block_scroller: a frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then a randomized soak.
module tb_block_scroller;
  localparam int XS = 1280;
  localparam int SP = 4;
  localparam int FL = 720;
  localparam int FM = 1848;

  logic        clk = 1'b0;
  logic        rst, start, halt;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [12:0] x_out;
  logic [15:0] freq_out;
  logic [7:0]  note_out;
  logic        active, passed;

  int errors = 0;
  int checks = 0;
  int pass_cnt = 0;

  block_scroller_if nif();

  block_scroller dut (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .start(start), .halt(halt), .note_bus(nif.slave),
    .x_out(x_out), .freq_out(freq_out), .note_out(note_out),
    .active(active), .passed(passed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: block position in pixels, game phase as two flags, frame history.
  int m_x, m_freq, m_note;
  bit m_req, m_act, m_pass, m_wait, m_play, m_valid;
  bit cond_prev1, cond_prev2;

  always @(posedge clk) begin : model
    bit cond_now;
    bit tick;
    cond_now = (hcount == 11'd0) && (vcount == 10'(FL));
    tick = cond_prev1 && !cond_prev2;
    if (rst) begin
      m_valid = 1'b1;
      m_x = XS; m_freq = 0; m_note = 0;
      m_req = 1'b0; m_act = 1'b0; m_pass = 1'b0;
      m_wait = 1'b0; m_play = 1'b0;
      cond_prev1 = 1'b0; cond_prev2 = 1'b0;
    end else begin
      m_pass = 1'b0;
      if (m_play) begin
        if (tick && !halt) begin
          if (m_x >= SP) m_x = m_x - SP;
          else begin
            m_x = XS; m_pass = 1'b1; m_play = 1'b0; m_wait = 1'b1;
          end
        end
      end else if (m_wait) begin
        if (nif.note_valid) begin
          m_freq = (int'(nif.note_freq) > FM) ? FM : int'(nif.note_freq);
          m_note = int'(nif.note_id);
          m_wait = 1'b0; m_play = 1'b1;
        end
      end else if (start) begin
        m_wait = 1'b1;
      end
      m_req = m_wait;
      m_act = m_play;
      cond_prev2 = cond_prev1;
      cond_prev1 = cond_now;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("x_out",    32'(x_out),        32'(m_x));
      chk("freq_out", 32'(freq_out),     32'(m_freq));
      chk("note_out", 32'(note_out),     32'(m_note));
      chk("note_req", 32'(nif.note_req), 32'(m_req));
      chk("active",   32'(active),       32'(m_act));
      chk("passed",   32'(passed),       32'(m_pass));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_scan();
    if ($urandom_range(0, 3) == 0) begin
      hcount = 11'd0;
      vcount = 10'($urandom_range(0, 719));
    end else begin
      hcount = 11'($urandom_range(1, 1649));
      vcount = 10'($urandom_range(0, 749));
    end
  endtask

  task automatic frame(input int hold);
    hcount = 11'd0;
    vcount = 10'(FL);
    repeat (hold) begin cyc(); pass_cnt += int'(passed); end
    idle_scan();
    repeat (3) begin cyc(); pass_cnt += int'(passed); end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic give_note(input logic [15:0] f, input logic [7:0] id);
    nif.note_freq  = f;
    nif.note_id    = id;
    nif.note_valid = 1'b1;
    cyc();
    nif.note_valid = 1'b0;
  endtask

  int cf[4] = '{3000, 1848, 1849, 0};
  int ce[4] = '{1848, 1848, 1848, 0};

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    nif.note_valid = 1'b0; nif.note_freq = 16'd0; nif.note_id = 8'd0;
    idle_scan();
    cyc(); cyc();
    rst = 1'b0;

    repeat (10) frame(1);
    chk("idle_x",      32'(x_out),        32'd1280);
    chk("idle_freq",   32'(freq_out),     32'd0);
    chk("idle_note",   32'(note_out),     32'd0);
    chk("idle_req",    32'(nif.note_req), 32'd0);
    chk("idle_active", 32'(active),       32'd0);

    do_start();
    chk("req_after_start", 32'(nif.note_req), 32'd1);
    give_note(16'd440, 8'h41);
    chk("hs_freq",   32'(freq_out),     32'd440);
    chk("hs_note",   32'(note_out),     32'h41);
    chk("hs_active", 32'(active),       32'd1);
    chk("hs_req",    32'(nif.note_req), 32'd0);
    repeat (3) frame(1);
    chk("three_ticks_x", 32'(x_out), 32'd1268);

    for (int i = 0; i < 4; i++) begin
      rst = 1'b1; cyc(); rst = 1'b0;
      do_start();
      give_note(16'(cf[i]), 8'(i + 1));
      chk("clamp_freq", 32'(freq_out), 32'(ce[i]));
    end

    pass_cnt = 0;
    repeat (320) frame(1);
    chk("x_at_zero",      32'(x_out),  32'd0);
    chk("no_early_pass",  32'(pass_cnt), 32'd0);
    frame(1);
    chk("respawn_x",      32'(x_out),        32'd1280);
    chk("one_pass_pulse", 32'(pass_cnt),     32'd1);
    chk("respawn_req",    32'(nif.note_req), 32'd1);
    chk("respawn_active", 32'(active),       32'd0);
    repeat (3) frame(1);
    chk("wait_hold_x",    32'(x_out),        32'd1280);

    give_note(16'd1000, 8'h22);
    frame(5);
    chk("held_cond_x", 32'(x_out), 32'd1276);
    halt = 1'b1;
    pass_cnt = 0;
    repeat (10) frame(1);
    chk("halt_x",    32'(x_out),    32'd1276);
    chk("halt_pass", 32'(pass_cnt), 32'd0);
    halt = 1'b0;
    frame(1);
    chk("unhalt_x", 32'(x_out), 32'd1272);

    repeat (158) frame(1);
    chk("x_640", 32'(x_out), 32'd640);
    hcount = 11'd0; vcount = 10'(FL);
    cyc();
    idle_scan();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_tick_x",      32'(x_out),    32'd1280);
    chk("rst_tick_freq",   32'(freq_out), 32'd0);
    chk("rst_tick_active", 32'(active),   32'd0);
    chk("rst_tick_passed", 32'(passed),   32'd0);

    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      halt = ($urandom_range(0, 7) == 0);
      nif.note_valid = ($urandom_range(0, 5) == 0);
      nif.note_freq = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(1840, 1856));
      nif.note_id = 8'($urandom);
      rst = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 2) == 0) begin
        hcount = 11'd0; vcount = 10'(FL);
      end else begin
        idle_scan();
      end
      cyc();
    end
    rst = 1'b0; start = 1'b0; halt = 1'b0; nif.note_valid = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
